// File: rtl/serv_arb_pkg.sv
// Shared types and constants for the SERV ibus/dbus Wishbone arbiter.
package serv_arb_pkg;

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} arb_state_t;
    typedef enum logic {IBUS, DBUS} arb_src_t;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/serv_arb_rr.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to whoever
// did not win last time.
module serv_arb_rr
    import serv_arb_pkg::*;
(
    input  logic     ibus_req,
    input  logic     dbus_req,
    input  arb_src_t last_grant,
    output arb_src_t grant
);

    always_comb begin
        grant = IBUS;
        if (ibus_req && dbus_req)
            grant = (last_grant == IBUS) ? DBUS : IBUS;
        else if (dbus_req)
            grant = DBUS;
    end

endmodule

// File: rtl/serv_wb_arbiter.sv
// Shares one registered Wishbone master port between the SERV ibus and dbus.
// Optional watchdog enabled by defining SERV_ARB_TIMEOUT_EN.
module serv_wb_arbiter
    import serv_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                i_rst,

    input  logic [ADDR_W-1:0]   i_ibus_adr,
    input  logic                i_ibus_cyc,
    output logic [DATA_W-1:0]   o_ibus_rdt,
    output logic                o_ibus_ack,

    input  logic [ADDR_W-1:0]   i_dbus_adr,
    input  logic [DATA_W-1:0]   i_dbus_dat,
    input  logic [DATA_W/8-1:0] i_dbus_sel,
    input  logic                i_dbus_we,
    input  logic                i_dbus_cyc,
    output logic [DATA_W-1:0]   o_dbus_rdt,
    output logic                o_dbus_ack,

    output logic                core_cyc,
    output logic                core_stb,
    output logic                core_we,
    output logic [DATA_W/8-1:0] core_wstrb,
    output logic [ADDR_W-1:0]   core_addr,
    output logic [DATA_W-1:0]   core_data_out,
    input  logic [DATA_W-1:0]   core_data_in,
    input  logic                core_ack,

    output logic                o_timeout
);

    arb_state_t          state;
    arb_src_t            last_grant;
    arb_src_t            cur_src;
    arb_src_t            grant;
    logic                in_gnt;
    logic                timeout_hit;
    logic                done;
    logic [DATA_W-1:0]   done_rdata;

    serv_arb_rr u_rr (
        .ibus_req   (i_ibus_cyc),
        .dbus_req   (i_dbus_cyc),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign in_gnt   = (state == GNT_I) || (state == GNT_D);
    assign core_stb = core_cyc;

`ifdef SERV_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;

    // Counter holds the number of completed wait cycles; the last one trips.
    assign timeout_hit = in_gnt && !core_ack && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign done_rdata  = core_ack ? core_data_in : DATA_W'(TIMEOUT_RDATA);

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            tmo_cnt   <= '0;
            o_timeout <= 1'b0;
        end else begin
            if (in_gnt)
                tmo_cnt <= tmo_cnt + 1'b1;
            else
                tmo_cnt <= '0;
            if (timeout_hit)
                o_timeout <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign done_rdata  = core_data_in;
    assign o_timeout   = 1'b0;
`endif

    assign done = in_gnt && (core_ack || timeout_hit);

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            last_grant    <= IBUS;
            cur_src       <= IBUS;
            core_cyc      <= 1'b0;
            core_we       <= 1'b0;
            core_wstrb    <= '0;
            core_addr     <= '0;
            core_data_out <= '0;
            o_ibus_rdt    <= '0;
            o_ibus_ack    <= 1'b0;
            o_dbus_rdt    <= '0;
            o_dbus_ack    <= 1'b0;
        end else begin
            o_ibus_ack <= 1'b0;
            o_dbus_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_ibus_cyc || i_dbus_cyc) begin
                        cur_src  <= grant;
                        core_cyc <= 1'b1;
                        if (grant == DBUS) begin
                            core_addr     <= i_dbus_adr;
                            core_we       <= i_dbus_we;
                            core_wstrb    <= i_dbus_sel;
                            core_data_out <= i_dbus_we ? i_dbus_dat : '0;
                            state         <= GNT_D;
                        end else begin
                            core_addr     <= i_ibus_adr;
                            core_we       <= 1'b0;
                            core_wstrb    <= '0;
                            core_data_out <= '0;
                            state         <= GNT_I;
                        end
                    end
                end
                GNT_I, GNT_D: begin
                    // A requester that already dropped cyc gets no ack.
                    if (done) begin
                        core_cyc <= 1'b0;
                        state    <= RESP;
                        if (state == GNT_I) begin
                            o_ibus_rdt <= done_rdata;
                            o_ibus_ack <= i_ibus_cyc;
                        end else begin
                            o_dbus_rdt <= done_rdata;
                            o_dbus_ack <= i_dbus_cyc;
                        end
                    end
                end
                RESP: begin
                    last_grant <= cur_src;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serv_wb_arbiter.sv
// Self-checking bench for serv_wb_arbiter: directed scenarios plus a
// randomized run against a transaction-level round-robin model.
module tb_serv_wb_arbiter;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_ibus_adr;
    logic        i_ibus_cyc;
    logic [31:0] o_ibus_rdt;
    logic        o_ibus_ack;
    logic [31:0] i_dbus_adr;
    logic [31:0] i_dbus_dat;
    logic [3:0]  i_dbus_sel;
    logic        i_dbus_we;
    logic        i_dbus_cyc;
    logic [31:0] o_dbus_rdt;
    logic        o_dbus_ack;
    logic        core_cyc;
    logic        core_stb;
    logic        core_we;
    logic [3:0]  core_wstrb;
    logic [31:0] core_addr;
    logic [31:0] core_data_out;
    logic [31:0] core_data_in;
    logic        core_ack;
    logic        o_timeout;

    int vecs = 0;
    int errs = 0;

    serv_wb_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .i_rst(i_rst),
        .i_ibus_adr(i_ibus_adr), .i_ibus_cyc(i_ibus_cyc),
        .o_ibus_rdt(o_ibus_rdt), .o_ibus_ack(o_ibus_ack),
        .i_dbus_adr(i_dbus_adr), .i_dbus_dat(i_dbus_dat), .i_dbus_sel(i_dbus_sel),
        .i_dbus_we(i_dbus_we), .i_dbus_cyc(i_dbus_cyc),
        .o_dbus_rdt(o_dbus_rdt), .o_dbus_ack(o_dbus_ack),
        .core_cyc(core_cyc), .core_stb(core_stb), .core_we(core_we),
        .core_wstrb(core_wstrb), .core_addr(core_addr), .core_data_out(core_data_out),
        .core_data_in(core_data_in), .core_ack(core_ack), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Every check samples 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [70:0] core_vec();
        return {core_cyc, core_stb, core_we, core_wstrb, core_addr, core_data_out};
    endfunction

    task automatic test_reset();
        logic [70:0] exp_v;
        i_rst = 1'b1;
        i_ibus_cyc = 1'b1; i_ibus_adr = 32'h10;
        step(); step();
        vecs++;
        if ({core_vec(), o_ibus_ack, o_dbus_ack, o_ibus_rdt, o_dbus_rdt, o_timeout} !== '0) begin
            errs++; $display("FAIL reset_outputs: got core=%h acks=%b%b expected all zero",
                             core_vec(), o_ibus_ack, o_dbus_ack);
        end
        #3 i_rst = 1'b0;
        step();
        exp_v = {1'b1, 1'b1, 1'b0, 4'b0000, 32'h10, 32'h0};
        vecs++;
        if (core_vec() !== exp_v) begin
            errs++; $display("FAIL reset_first_grant: got %h expected %h", core_vec(), exp_v);
        end
        core_ack = 1'b1; core_data_in = 32'h13;
        step();
        core_ack = 1'b0;
        vecs++;
        if ({o_ibus_ack, o_dbus_ack, o_ibus_rdt, core_cyc} !== {1'b1, 1'b0, 32'h13, 1'b0}) begin
            errs++; $display("FAIL reset_first_ack: got ack=%b%b rdt=%h cyc=%b expected 10 00000013 0",
                             o_ibus_ack, o_dbus_ack, o_ibus_rdt, core_cyc);
        end
        i_ibus_cyc = 1'b0;
        step();
        vecs++;
        if ({o_ibus_ack, o_dbus_ack} !== 2'b00) begin
            errs++; $display("FAIL reset_ack_width: acks=%b%b expected 00", o_ibus_ack, o_dbus_ack);
        end
    endtask

    task automatic test_dbus_write();
        logic [70:0] exp_v;
        i_dbus_adr = 32'h100; i_dbus_dat = 32'hCAFE_F00D; i_dbus_sel = 4'b0011;
        i_dbus_we = 1'b1; i_dbus_cyc = 1'b1;
        step();
        exp_v = {1'b1, 1'b1, 1'b1, 4'b0011, 32'h100, 32'hCAFE_F00D};
        for (int w = 0; w < 6; w++) begin
            vecs++;
            if (core_vec() !== exp_v || o_dbus_ack !== 1'b0 || o_ibus_ack !== 1'b0) begin
                errs++; $display("FAIL dbus_write_hold[%0d]: got %h acks=%b%b expected %h acks=00",
                                 w, core_vec(), o_ibus_ack, o_dbus_ack, exp_v);
            end
            if (w < 5) step();
        end
        core_ack = 1'b1; core_data_in = 32'h1234_5678;
        step();
        core_ack = 1'b0;
        vecs++;
        if ({o_ibus_ack, o_dbus_ack, core_cyc} !== 3'b010) begin
            errs++; $display("FAIL dbus_write_ack: got ack=%b%b cyc=%b expected 01 0",
                             o_ibus_ack, o_dbus_ack, core_cyc);
        end
        i_dbus_cyc = 1'b0; i_dbus_we = 1'b0;
        step();
        vecs++;
        if ({o_ibus_ack, o_dbus_ack} !== 2'b00) begin
            errs++; $display("FAIL dbus_write_single_pulse: acks=%b%b expected 00", o_ibus_ack, o_dbus_ack);
        end
    endtask

    task automatic test_tie();
        bit exp_d;
        i_rst = 1'b1;
        step();
        i_ibus_adr = 32'h200; i_ibus_cyc = 1'b1;
        i_dbus_adr = 32'h300; i_dbus_we = 1'b0; i_dbus_sel = 4'hF; i_dbus_cyc = 1'b1;
        i_rst = 1'b0;
        step();
        exp_d = 1'b1;
        for (int r = 0; r < 4; r++) begin
            vecs++;
            if (core_cyc !== 1'b1 || core_addr !== (exp_d ? 32'h300 : 32'h200)) begin
                errs++; $display("FAIL tie_grant[%0d]: cyc=%b addr=%h expected 1 %h",
                                 r, core_cyc, core_addr, exp_d ? 32'h300 : 32'h200);
            end
            core_ack = 1'b1; core_data_in = 32'hA000 + r;
            step();
            core_ack = 1'b0;
            vecs++;
            if ({o_ibus_ack, o_dbus_ack} !== {~exp_d, exp_d}) begin
                errs++; $display("FAIL tie_ack[%0d]: acks=%b%b expected %b%b",
                                 r, o_ibus_ack, o_dbus_ack, ~exp_d, exp_d);
            end
            step(); step();
            exp_d = ~exp_d;
        end
        i_ibus_cyc = 1'b0; i_dbus_cyc = 1'b0;
        core_ack = 1'b1;
        step();
        core_ack = 1'b0;
        step(); step();
    endtask

    task automatic test_reset_mid();
        i_dbus_adr = 32'h400; i_dbus_dat = 32'h5A5A_5A5A; i_dbus_sel = 4'b1100;
        i_dbus_we = 1'b1; i_dbus_cyc = 1'b1;
        step(); step(); step();
        i_rst = 1'b1;
        #1;
        vecs++;
        if ({core_vec(), o_ibus_ack, o_dbus_ack, o_timeout} !== '0) begin
            errs++; $display("FAIL reset_mid_async: got core=%h expected all zero", core_vec());
        end
        i_dbus_cyc = 1'b0; i_dbus_we = 1'b0;
        step();
        i_rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            vecs++;
            if ({core_cyc, o_ibus_ack, o_dbus_ack} !== 3'b000) begin
                errs++; $display("FAIL reset_mid_quiet[%0d]: cyc=%b acks=%b%b expected 000",
                                 c, core_cyc, o_ibus_ack, o_dbus_ack);
            end
        end
    endtask

    task automatic test_spurious_ack();
        core_ack = 1'b1; core_data_in = 32'h5555_5555;
        for (int c = 0; c < 3; c++) begin
            step();
            vecs++;
            if ({core_cyc, o_ibus_ack, o_dbus_ack} !== 3'b000) begin
                errs++; $display("FAIL spurious_ack[%0d]: cyc=%b acks=%b%b expected 000",
                                 c, core_cyc, o_ibus_ack, o_dbus_ack);
            end
        end
        core_ack = 1'b0;
        i_ibus_adr = 32'h20; i_ibus_cyc = 1'b1;
        step();
        vecs++;
        if (core_cyc !== 1'b1 || core_addr !== 32'h20) begin
            errs++; $display("FAIL spurious_then_grant: cyc=%b addr=%h expected 1 00000020", core_cyc, core_addr);
        end
        core_ack = 1'b1; core_data_in = 32'h21;
        step();
        core_ack = 1'b0; i_ibus_cyc = 1'b0;
        step();
    endtask

    task automatic test_abort();
        i_dbus_adr = 32'h500; i_dbus_we = 1'b0; i_dbus_sel = 4'hF; i_dbus_cyc = 1'b1;
        step();
        vecs++;
        if (core_cyc !== 1'b1 || core_addr !== 32'h500 || core_data_out !== 32'h0) begin
            errs++; $display("FAIL abort_grant: cyc=%b addr=%h dout=%h expected 1 00000500 00000000",
                             core_cyc, core_addr, core_data_out);
        end
        i_dbus_cyc = 1'b0;
        step();
        vecs++;
        if (core_cyc !== 1'b1) begin
            errs++; $display("FAIL abort_master_held: cyc=%b expected 1", core_cyc);
        end
        core_ack = 1'b1; core_data_in = 32'h77;
        step();
        core_ack = 1'b0;
        vecs++;
        if ({core_cyc, o_ibus_ack, o_dbus_ack} !== 3'b000) begin
            errs++; $display("FAIL abort_no_ack: cyc=%b acks=%b%b expected 000", core_cyc, o_ibus_ack, o_dbus_ack);
        end
        step();
    endtask

    // Model: one transfer at a time; lone requester wins, a tie goes to the
    // side that did not win the previous transfer.
    task automatic test_random();
        bit          pi, pd, m_last_d, win_d, dwe;
        logic [31:0] ia, da, dd, rd;
        logic [3:0]  dsel;
        logic [70:0] exp_v;
        int          waits;
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        pi = 0; pd = 0; m_last_d = 0;
        ia = 0; da = 0; dd = 0; dsel = 0; dwe = 0;
        for (int t = 0; t < 40; t++) begin
            if (!pi && $urandom_range(0, 1) == 1) begin
                pi = 1; ia = $urandom & 32'hFFFF_FFFC;
            end
            if (!pd && $urandom_range(0, 1) == 1) begin
                pd = 1; da = $urandom; dd = $urandom; dsel = 4'($urandom); dwe = 1'($urandom);
            end
            if (!pi && !pd) begin
                pi = 1; ia = $urandom & 32'hFFFF_FFFC;
            end
            i_ibus_cyc = pi; i_ibus_adr = ia;
            i_dbus_cyc = pd; i_dbus_adr = da; i_dbus_dat = dd; i_dbus_sel = dsel; i_dbus_we = dwe;
            step();
            win_d = (pi && pd) ? !m_last_d : pd;
            exp_v = win_d ? {1'b1, 1'b1, dwe, dsel, da, dwe ? dd : 32'h0}
                          : {1'b1, 1'b1, 1'b0, 4'h0, ia, 32'h0};
            vecs++;
            if (core_vec() !== exp_v) begin
                errs++; $display("FAIL rand_grant[%0d]: got %h expected %h", t, core_vec(), exp_v);
            end
            waits = $urandom_range(0, 3);
            for (int w = 0; w < waits; w++) begin
                step();
                vecs++;
                if (core_vec() !== exp_v || {o_ibus_ack, o_dbus_ack} !== 2'b00) begin
                    errs++; $display("FAIL rand_wait[%0d]: got %h acks=%b%b expected %h acks=00",
                                     t, core_vec(), o_ibus_ack, o_dbus_ack, exp_v);
                end
            end
            rd = $urandom;
            core_ack = 1'b1; core_data_in = rd;
            step();
            core_ack = 1'b0;
            vecs++;
            if ({o_ibus_ack, o_dbus_ack} !== {~win_d, win_d} || core_cyc !== 1'b0 ||
                (win_d ? o_dbus_rdt : o_ibus_rdt) !== rd) begin
                errs++; $display("FAIL rand_resp[%0d]: acks=%b%b cyc=%b rdt=%h expected %b%b 0 %h",
                                 t, o_ibus_ack, o_dbus_ack, core_cyc,
                                 win_d ? o_dbus_rdt : o_ibus_rdt, ~win_d, win_d, rd);
            end
            if (win_d) begin pd = 0; i_dbus_cyc = 1'b0; end
            else       begin pi = 0; i_ibus_cyc = 1'b0; end
            m_last_d = win_d;
            step();
        end
        i_ibus_cyc = 1'b0; i_dbus_cyc = 1'b0;
        if (pi || pd) begin
            step();
            core_ack = 1'b1;
            step();
            core_ack = 1'b0;
            step();
        end
    endtask

`ifdef SERV_ARB_TIMEOUT_EN
    task automatic test_timeout();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        i_ibus_adr = 32'h40; i_ibus_cyc = 1'b1;
        step();
        for (int c = 0; c < 8; c++) begin
            vecs++;
            if (core_cyc !== 1'b1 || o_ibus_ack !== 1'b0) begin
                errs++; $display("FAIL timeout_wait[%0d]: cyc=%b ack=%b expected 1 0", c, core_cyc, o_ibus_ack);
            end
            step();
        end
        vecs++;
        if ({core_cyc, o_ibus_ack, o_ibus_rdt, o_timeout} !== {1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1}) begin
            errs++; $display("FAIL timeout_fire: cyc=%b ack=%b rdt=%h to=%b expected 0 1 deadbeef 1",
                             core_cyc, o_ibus_ack, o_ibus_rdt, o_timeout);
        end
        i_ibus_cyc = 1'b0;
        repeat (3) step();
        vecs++;
        if (o_timeout !== 1'b1) begin
            errs++; $display("FAIL timeout_sticky: to=%b expected 1", o_timeout);
        end
        i_rst = 1'b1;
        #1;
        vecs++;
        if (o_timeout !== 1'b0) begin
            errs++; $display("FAIL timeout_clear: to=%b expected 0", o_timeout);
        end
        step();
        i_rst = 1'b0;
        step();
    endtask
`endif

    initial begin
        i_rst = 1'b1;
        i_ibus_adr = '0; i_ibus_cyc = 1'b0;
        i_dbus_adr = '0; i_dbus_dat = '0; i_dbus_sel = '0; i_dbus_we = 1'b0; i_dbus_cyc = 1'b0;
        core_data_in = '0; core_ack = 1'b0;
        test_reset();
        test_dbus_write();
        test_tie();
        test_reset_mid();
        test_spurious_ack();
        test_abort();
        test_random();
`ifdef SERV_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
